// File: rtl/ex_dispatch_arbiter.sv
// ex_dispatch_arbiter: round-robin arbiter that merges NUM_REQS dispatch lanes
// into one execution unit through a 2-entry {lane, payload} FIFO. A lane is
// granted only while the FIFO has a free slot. Cycles in which requests are
// pending but nothing is granted are counted in a saturating stall counter.
module ex_dispatch_arbiter #(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 64,
    parameter int CTR_W    = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQS-1:0]         req_valid,
    input  logic [NUM_REQS*DATAW-1:0]   req_data,
    output logic [NUM_REQS-1:0]         req_ready,
    output logic                        out_valid,
    output logic [DATAW-1:0]            out_data,
    output logic [$clog2(NUM_REQS)-1:0] out_sel,
    input  logic                        out_ready,
    output logic [CTR_W-1:0]            stall_count
);

    localparam int SELW = $clog2(NUM_REQS);

    // FIFO storage and bookkeeping
    logic [DATAW-1:0]      mem_data [2];
    logic [SELW-1:0]       mem_sel  [2];
    logic [1:0]            count;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [SELW-1:0]       rr_ptr;

    logic                  can_accept;
    logic [2*NUM_REQS-1:0] rot_valid;
    logic                  gnt_vld;
    logic [SELW-1:0]       gnt_idx;
    logic [DATAW-1:0]      gnt_data;
    logic                  push;
    logic                  pop;
    logic [SELW-1:0]       rr_next;

    // Acceptance depends only on stored occupancy, never on out_ready
    assign can_accept = (count < 2'd2);

    // Search upward from rr_ptr: rotate a doubled copy of the valids so the
    // first set bit of the low NUM_REQS bits is the winner, offset by rr_ptr.
    always_comb begin
        logic [SELW:0] sum;
        rot_valid = {req_valid, req_valid} >> rr_ptr;
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!gnt_vld && rot_valid[i]) begin
                gnt_vld = 1'b1;
                sum     = {1'b0, rr_ptr} + (SELW+1)'(i);
                if (sum >= (SELW+1)'(NUM_REQS))
                    sum = sum - (SELW+1)'(NUM_REQS);
                gnt_idx = sum[SELW-1:0];
            end
        end
    end

    // Payload mux for the granted lane
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (SELW'(i) == gnt_idx)
                gnt_data = req_data[i*DATAW +: DATAW];
        end
    end

    assign push = gnt_vld && can_accept && !reset;

    // One-hot accept for the granted lane only
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++)
            req_ready[i] = push && (SELW'(i) == gnt_idx);
    end

    assign rr_next   = (gnt_idx == SELW'(NUM_REQS-1)) ? '0 : gnt_idx + 1'b1;

    assign out_valid = (count != 2'd0) && !reset;
    assign out_data  = mem_data[rd_ptr];
    assign out_sel   = mem_sel[rd_ptr];
    assign pop       = out_valid && out_ready;

    // Payload storage needs no reset; occupancy decides validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= gnt_data;
            mem_sel[wr_ptr]  <= gnt_idx;
        end
    end

    // FIFO pointers/count, round-robin pointer and stall counter
    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            rr_ptr      <= '0;
            stall_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
                rr_ptr <= rr_next;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if ((|req_valid) && !push && (stall_count != {CTR_W{1'b1}}))
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule
